// File: rtl/onehot_pkg.sv
// Shared encodings for the ring counter family.
package onehot_pkg;
   localparam logic MODE_ONEHOT  = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
endpackage

// File: rtl/onehot_pattern_gen.sv
// Combinational ring pattern for position p: one-hot bit, or Johnson fill.
module onehot_pattern_gen
   import onehot_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IW    = $clog2(2*WIDTH)
) (
   input  logic             mode,
   input  logic [IW-1:0]    p,
   output logic [WIDTH-1:0] pattern
);
   always_comb begin
      int pi;
      pi      = int'(p);
      pattern = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (mode == MODE_JOHNSON)
            // first WIDTH positions fill from LSB, the rest drain from LSB
            pattern[i] = (pi <= WIDTH) ? (i < pi) : (i >= pi - WIDTH);
         else
            pattern[i] = (i == pi);
      end
   end
endmodule

// File: rtl/onehot_ring_counter.sv
// Prescaled one-hot / Johnson ring counter with load, direction and wrap/err pulses.
module onehot_ring_counter
   import onehot_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DIV   = 1,
   localparam int IW    = $clog2(2*WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             EN,
   input  logic             DIR,
   input  logic             MODE,
   input  logic             LOAD,
   input  logic [IW-1:0]    LOAD_IDX,
   output logic [WIDTH-1:0] counter_onehot,
   output logic [IW-1:0]    idx,
   output logic             wrap,
   output logic             err
);
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0]    pre_q;
   logic             mode_q;
   logic [IW:0]      n_cur;
   logic [IW-1:0]    idx_last;
   logic             load_ok;
   logic             tick;
   logic [IW-1:0]    gen_idx;
   logic [WIDTH-1:0] gen_pat;
   logic [WIDTH-1:0] step_pat;

   assign n_cur    = (mode_q == MODE_JOHNSON) ? (IW+1)'(2*WIDTH) : (IW+1)'(WIDTH);
   assign idx_last = IW'(n_cur - 1'b1);
   assign load_ok  = ({1'b0, LOAD_IDX} < n_cur);
   assign tick     = EN && (pre_q == PW'(DIV-1));

   // Loads use the requested index; reset and mode change both land on position 0.
   // The pattern always follows the mode being registered on this edge.
   assign gen_idx = (RST_N && LOAD) ? LOAD_IDX : '0;

   onehot_pattern_gen #(.WIDTH(WIDTH), .IW(IW)) u_gen (
      .mode    (MODE),
      .p       (gen_idx),
      .pattern (gen_pat)
   );

   always_comb begin
      step_pat = counter_onehot;
      case ({mode_q, DIR})
         {MODE_ONEHOT,  1'b0}: step_pat = {counter_onehot[WIDTH-2:0], counter_onehot[WIDTH-1]};
         {MODE_ONEHOT,  1'b1}: step_pat = {counter_onehot[0], counter_onehot[WIDTH-1:1]};
         {MODE_JOHNSON, 1'b0}: step_pat = {counter_onehot[WIDTH-2:0], ~counter_onehot[WIDTH-1]};
         default:              step_pat = {~counter_onehot[0], counter_onehot[WIDTH-1:1]};
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         idx            <= '0;
         pre_q          <= '0;
         wrap           <= 1'b0;
         err            <= 1'b0;
         mode_q         <= MODE;
         counter_onehot <= gen_pat;
      end else begin
         wrap <= 1'b0;
         err  <= 1'b0;
         if (LOAD) begin
            mode_q <= MODE;
            if (load_ok) begin
               idx            <= LOAD_IDX;
               counter_onehot <= gen_pat;
               pre_q          <= '0;
            end else begin
               err <= 1'b1;
            end
         end else if (MODE != mode_q) begin
            mode_q         <= MODE;
            idx            <= '0;
            counter_onehot <= gen_pat;
            pre_q          <= '0;
         end else if (EN) begin
            if (tick) begin
               pre_q          <= '0;
               counter_onehot <= step_pat;
               if (DIR) begin
                  idx  <= (idx == '0) ? idx_last : idx - 1'b1;
                  wrap <= (idx == '0);
               end else begin
                  idx  <= (idx == idx_last) ? '0 : idx + 1'b1;
                  wrap <= (idx == idx_last);
               end
            end else begin
               pre_q <= pre_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/onehot_ring_counter.md
ONEHOT_RING_COUNTER -- requirements
Module: onehot_ring_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, ring length in bits (legal >= 2).
REQ-002 SHALL have parameter DIV, default 1, enabled cycles per step (legal >= 1).
REQ-003 SHALL derive local constant IW = clog2(2*WIDTH), the index width.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have port CLK  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port RST_N  input  1  synchronous active-low reset.
REQ-007 SHALL have port EN  input  1  count enable; feeds the prescaler.
REQ-008 SHALL have port DIR  input  1  0 = up (toward MSB), 1 = down.
REQ-009 SHALL have port MODE  input  1  0 = one-hot ring, 1 = Johnson (twisted) ring.
REQ-010 SHALL have port LOAD  input  1  synchronous position load request.
REQ-011 SHALL have port LOAD_IDX  input  IW  target position for LOAD.
REQ-012 SHALL have port counter_onehot  output  WIDTH  registered ring pattern.
REQ-013 SHALL have port idx  output  IW  registered position, 0..N-1.
REQ-014 SHALL have port wrap  output  1  one-cycle pulse on position wrap.
REQ-015 SHALL have port err  output  1  one-cycle pulse on rejected LOAD.

Function
REQ-016 SHALL use N = WIDTH states in one-hot mode and N = 2*WIDTH in Johnson mode.
REQ-017 SHALL drive pattern(p) in one-hot mode as a single 1 at bit p.
REQ-018 SHALL drive pattern(p) in Johnson mode as bits [p-1:0] = 1 for p <= WIDTH, and bits [WIDTH-1:p-WIDTH] = 1 for p > WIDTH; all other bits 0.
REQ-019 SHALL keep counter_onehot == pattern(idx) on every cycle after reset.
REQ-020 SHALL run a prescaler of 0..DIV-1 that advances only when EN=1; tick = EN && prescaler == DIV-1.
REQ-021 SHALL make a step on tick: up gives idx+1 mod N, down gives idx-1 mod N; the output updates on the same edge (latency 1).
REQ-022 SHALL pulse wrap on the cycle the output shows the wrapped value: N-1 to 0 going up, 0 to N-1 going down.
REQ-023 SHALL hold idx, pattern and prescaler while EN=0; wrap SHALL be 0 on those cycles.
REQ-024 SHALL register MODE internally; when MODE differs from the registered value: idx=0, pattern(0) of the new mode, prescaler cleared, no wrap.
REQ-025 SHALL, on LOAD with LOAD_IDX < N: set idx=LOAD_IDX, pattern(LOAD_IDX), clear the prescaler, no wrap.
REQ-026 SHALL, on LOAD with LOAD_IDX >= N: leave state unchanged, pulse err for one cycle, and suppress the step on that cycle.
REQ-027 SHALL apply priority per edge: reset > LOAD > MODE change > step; a lower-priority event on the same cycle is discarded.
REQ-028 SHALL evaluate a LOAD coinciding with a MODE change against N of the current registered mode; MODE is registered on that edge as well.
REQ-029 SHALL follow DIR changes on the next tick; DIR does not affect the prescaler.

Reset
REQ-030 SHALL, when RST_N=0 at an edge: idx=0, prescaler=0, wrap=0, err=0, registered mode=MODE.
REQ-031 SHALL set counter_onehot = pattern(0) of the sampled MODE on reset: one-hot gives 0..01; Johnson gives all zeros.
REQ-032 SHALL override EN, LOAD and DIR while RST_N=0; reset asserted mid-count takes effect on the next edge.

Structure
REQ-033 SHALL take the mode encoding constants MODE_ONEHOT=0 and MODE_JOHNSON=1 from shared package onehot_pkg.
REQ-034 SHALL implement pattern(p) as a combinational sub-module onehot_pattern_gen (WIDTH, MODE, p in; pattern out), used for load and reset values.
REQ-035 SHALL implement the step as a one-hot rotate or Johnson shift of the registered pattern, with idx tracked in parallel.

Verification
REQ-036 SHALL cover: WIDTH=8, DIV=1, MODE=0, EN=1, up for 9 cycles -> 01,02,..,80,01; wrap high only with 01; idx 0..7,0.
REQ-037 SHALL cover: MODE=1, WIDTH=4, up -> 0,1,3,7,F,E,C,8,0; wrap on return to 0; then DIR=1 from 0 -> 8, idx=7, wrap=1.
REQ-038 SHALL cover: DIV=3, EN toggled 1,1,0,1 -> one step after the 3rd enabled cycle; hold while EN=0.
REQ-039 SHALL cover: LOAD_IDX=5 (one-hot, W=8) -> pattern 20, idx=5; LOAD_IDX=9 -> err=1, state unchanged; LOAD with tick -> load only.
REQ-040 SHALL cover: MODE 0->1 mid-count at idx=3 -> pattern 0, idx=0; RST_N=0 mid-count with MODE=0 -> pattern 01, idx=0, wrap=0.
